// File: rtl/gmii_width_buffer_pkg.sv
// gmii_width_buffer shared types: drop reasons, frame descriptor, read FSM.
// Descriptor fields are 16 bits: DATA_DEPTH and MAX_FRAME_LEN stay below 64K.
package gmii_width_buffer_pkg;

  localparam int DESC_W = 16;

  typedef enum logic [1:0] {
    DROP_NONE,
    DROP_ERROR,
    DROP_LEN,
    DROP_FULL
  } drop_reason_t;

  typedef struct packed {
    logic [DESC_W-1:0] length;
    logic [DESC_W-1:0] start_addr;
  } frame_desc_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_LOAD,
    RD_STREAM
  } read_state_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gmii_width_buffer_if.sv
// Bundle of the GMII byte input and the packed output stream.
// master: byte source + stream sink; slave: the buffer itself.
interface gmii_width_buffer_if #(
  parameter int OUTPUT_BYTES  = 4,
  parameter int MAX_FRAME_LEN = 2048
);

  localparam int BW = $clog2(OUTPUT_BYTES + 1);
  localparam int LW = $clog2(MAX_FRAME_LEN + 1);

  logic [7:0]                Input_data;
  logic                      Input_valid;
  logic                      Input_error;
  logic                      Input_accepted;
  logic [8*OUTPUT_BYTES-1:0] Output_data;
  logic [BW-1:0]             Output_bytes;
  logic [LW-1:0]             Output_length;
  logic                      Output_valid;
  logic                      Output_last;
  logic                      Output_ready;

  modport master (
    output Input_data, Input_valid, Input_error,
    output Output_ready,
    input  Input_accepted,
    input  Output_data, Output_bytes, Output_length,
    input  Output_valid, Output_last
  );

  modport slave (
    input  Input_data, Input_valid, Input_error,
    input  Output_ready,
    output Input_accepted,
    output Output_data, Output_bytes, Output_length,
    output Output_valid, Output_last
  );

endinterface

// File: rtl/gmii_width_buffer_sdp_ram.sv
// gmii_sdp_ram: simple dual-port RAM, one write port, registered read.
// Ports: clk, wr_en/wr_addr/wr_data, rd_en/rd_addr, rd_data (1-cycle).
module gmii_sdp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/gmii_width_buffer.sv
// Store-and-forward GMII frame buffer packing bytes into OUTPUT_BYTES words.
// Ports: Clk, Rst_n, bus (gmii_width_buffer_if.slave); optional drop/frame
// counters under GMII_WIDTH_BUFFER_STATS_EN. DATA_DEPTH is a power of 2.
module gmii_width_buffer
  import gmii_width_buffer_pkg::*;
#(
  parameter int OUTPUT_BYTES  = 4,
  parameter int DATA_DEPTH    = 1024,
  parameter int FRAME_DEPTH   = 64,
  parameter int MAX_FRAME_LEN = 2048
) (
  input logic Clk,
  input logic Rst_n,
  gmii_width_buffer_if.slave bus
`ifdef GMII_WIDTH_BUFFER_STATS_EN
  ,
  output logic [15:0] Drop_error_count,
  output logic [15:0] Drop_len_count,
  output logic [15:0] Drop_full_count,
  output logic [15:0] Frame_count
`endif
);

  localparam int DW = 8 * OUTPUT_BYTES;
  localparam int AW = $clog2(DATA_DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = $clog2(FRAME_DEPTH);
  localparam int BW = $clog2(OUTPUT_BYTES + 1);
  localparam int LW = $clog2(MAX_FRAME_LEN + 1);
  localparam int SW = (OUTPUT_BYTES > 1) ? $clog2(OUTPUT_BYTES) : 1;

  // write side
  logic         in_frame_q, in_frame_d;
  logic [SW-1:0] lane_q, lane_d;
  logic [DW-1:0] stage_q, stage_d;
  logic [LW-1:0] len_q, len_d;
  drop_reason_t drop_q, drop_d;
  drop_reason_t end_reason;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] cm_ptr_q, cm_ptr_d;
  logic         acc_q, acc_d;
  logic [PW-1:0] used;
  logic         data_full;
  logic         ram_we;
  logic [DW-1:0] ram_wdata;
  logic         frame_end;
  logic         push;

  // descriptor fifo
  frame_desc_t  dq_mem [FRAME_DEPTH];
  frame_desc_t  desc_in;
  frame_desc_t  desc_head;
  logic [FW:0]  dq_wr_q, dq_rd_q;
  logic         dq_full;
  logic         pop_desc;

  // read side
  read_state_t  state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [LW-1:0] words_q, words_d;
  logic [BW-1:0] lb_q, lb_d;
  logic [LW-1:0] len_out_q, len_out_d;
  logic         inflight_q, inflight_d;
  logic         mlast_q, mlast_d;
  logic [BW-1:0] mbytes_q, mbytes_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [DW-1:0] sd_q [2];
  logic [DW-1:0] sd_d [2];
  logic [BW-1:0] sb_q [2];
  logic [BW-1:0] sb_d [2];
  logic         sl_q [2];
  logic         sl_d [2];
  logic [PW-1:0] free_ptr_q;
  logic [DW-1:0] ram_rdata;
  logic         issue;
  logic         pop;
  logic [2:0]   credit;
  logic [31:0]  len32;

  gmii_sdp_ram #(
    .WIDTH (DW),
    .DEPTH (DATA_DEPTH)
  ) u_ram (
    .clk     (Clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (ram_wdata),
    .rd_en   (issue),
    .rd_addr (rd_addr_q),
    .rd_data (ram_rdata)
  );

  assign used      = wr_ptr_q - free_ptr_q;
  assign data_full = (used == PW'(DATA_DEPTH));
  assign dq_full   = ((dq_wr_q - dq_rd_q) == (FW+1)'(FRAME_DEPTH));
  assign desc_head = dq_mem[dq_rd_q[FW-1:0]];

  always_comb begin
    in_frame_d = bus.Input_valid;
    lane_d     = lane_q;
    stage_d    = stage_q;
    len_d      = len_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    acc_d      = acc_q;
    ram_we     = 1'b0;
    ram_wdata  = stage_q;
    frame_end  = 1'b0;
    push       = 1'b0;
    end_reason = DROP_NONE;
    if (bus.Input_valid) begin
      if (drop_q == DROP_NONE) begin
        if (bus.Input_error) begin
          drop_d = DROP_ERROR;
        end else if (len_q == LW'(MAX_FRAME_LEN)) begin
          drop_d = DROP_LEN;
        end else begin
          len_d = len_q + 1'b1;
          stage_d[lane_q*8 +: 8] = bus.Input_data;
          if (lane_q == SW'(OUTPUT_BYTES - 1)) begin
            lane_d = '0;
            if (data_full) begin
              drop_d = DROP_FULL;
            end else begin
              ram_we    = 1'b1;
              ram_wdata = stage_d;
              wr_ptr_d  = wr_ptr_q + 1'b1;
            end
            stage_d = '0;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
    end else if (in_frame_q) begin
      // first idle cycle: flush the partial word, then commit or rewind
      frame_end  = 1'b1;
      end_reason = drop_q;
      if (end_reason == DROP_NONE && lane_q != '0) begin
        if (data_full) begin
          end_reason = DROP_FULL;
        end else begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end
      if (end_reason == DROP_NONE && dq_full) end_reason = DROP_FULL;
      if (end_reason == DROP_NONE) begin
        push     = 1'b1;
        cm_ptr_d = wr_ptr_d;
        acc_d    = 1'b1;
      end else begin
        wr_ptr_d = cm_ptr_q;
        acc_d    = 1'b0;
      end
      lane_d  = '0;
      stage_d = '0;
      len_d   = '0;
      drop_d  = DROP_NONE;
    end
    desc_in.length     = DESC_W'(len_q);
    desc_in.start_addr = DESC_W'(cm_ptr_q[AW-1:0]);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      in_frame_q <= 1'b0;
      lane_q     <= '0;
      stage_q    <= '0;
      len_q      <= '0;
      drop_q     <= DROP_NONE;
      wr_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      acc_q      <= 1'b0;
      dq_wr_q    <= '0;
    end else begin
      in_frame_q <= in_frame_d;
      lane_q     <= lane_d;
      stage_q    <= stage_d;
      len_q      <= len_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      acc_q      <= acc_d;
      dq_wr_q    <= dq_wr_q + (FW+1)'(push);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) dq_mem[dq_wr_q[FW-1:0]] <= desc_in;
  end

  assign pop    = (cnt_q != 2'd0) && bus.Output_ready;
  // skid slots + in-flight read must never exceed 2 entries
  assign credit = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign len32  = 32'(desc_head.length);

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    words_d   = words_q;
    lb_d      = lb_q;
    len_out_d = len_out_q;
    mlast_d   = mlast_q;
    mbytes_d  = mbytes_q;
    pop_desc  = 1'b0;
    issue     = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (dq_rd_q != dq_wr_q) begin
          pop_desc  = 1'b1;
          rd_addr_d = AW'(desc_head.start_addr);
          len_out_d = LW'(len32);
          words_d   = LW'((len32 + 32'(OUTPUT_BYTES) - 32'd1)
                          / 32'(OUTPUT_BYTES));
          lb_d      = BW'(((len32 - 32'd1) % 32'(OUTPUT_BYTES))
                          + 32'd1);
          state_d   = RD_LOAD;
        end
      end
      RD_LOAD, RD_STREAM: begin
        if (words_q != '0 && credit < 3'd2) begin
          issue     = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          words_d   = words_q - 1'b1;
          mlast_d   = (words_q == LW'(1));
          mbytes_d  = (words_q == LW'(1)) ? lb_q
                                          : BW'(OUTPUT_BYTES);
        end
        if (state_q == RD_LOAD) begin
          state_d = RD_STREAM;
        end else if (pop && sl_q[0]) begin
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = issue;
    cnt_d      = cnt_q;
    for (int i = 0; i < 2; i++) begin
      sd_d[i] = sd_q[i];
      sb_d[i] = sb_q[i];
      sl_d[i] = sl_q[i];
    end
    if (pop) begin
      sd_d[0] = sd_q[1];
      sb_d[0] = sb_q[1];
      sl_d[0] = sl_q[1];
      cnt_d   = cnt_q - 1'b1;
    end
    if (inflight_q) begin
      sd_d[cnt_d[0]] = ram_rdata;
      sb_d[cnt_d[0]] = mbytes_q;
      sl_d[cnt_d[0]] = mlast_q;
      cnt_d          = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= RD_IDLE;
      rd_addr_q  <= '0;
      words_q    <= '0;
      lb_q       <= '0;
      len_out_q  <= '0;
      inflight_q <= 1'b0;
      mlast_q    <= 1'b0;
      mbytes_q   <= '0;
      cnt_q      <= '0;
      free_ptr_q <= '0;
      dq_rd_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        sd_q[i] <= '0;
        sb_q[i] <= '0;
        sl_q[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      words_q    <= words_d;
      lb_q       <= lb_d;
      len_out_q  <= len_out_d;
      inflight_q <= inflight_d;
      mlast_q    <= mlast_d;
      mbytes_q   <= mbytes_d;
      cnt_q      <= cnt_d;
      free_ptr_q <= free_ptr_q + PW'(pop);
      dq_rd_q    <= dq_rd_q + (FW+1)'(pop_desc);
      for (int i = 0; i < 2; i++) begin
        sd_q[i] <= sd_d[i];
        sb_q[i] <= sb_d[i];
        sl_q[i] <= sl_d[i];
      end
    end
  end

  assign bus.Input_accepted = acc_q;
  assign bus.Output_valid   = (cnt_q != 2'd0);
  assign bus.Output_data    = sd_q[0];
  assign bus.Output_bytes   = sb_q[0];
  assign bus.Output_last    = sl_q[0];
  assign bus.Output_length  = len_out_q;

`ifdef GMII_WIDTH_BUFFER_STATS_EN
  logic [15:0] err_cnt_q, lenc_cnt_q, full_cnt_q, frm_cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      err_cnt_q  <= '0;
      lenc_cnt_q <= '0;
      full_cnt_q <= '0;
      frm_cnt_q  <= '0;
    end else if (frame_end) begin
      if (end_reason == DROP_ERROR) err_cnt_q <= sat_inc(err_cnt_q);
      if (end_reason == DROP_LEN) lenc_cnt_q <= sat_inc(lenc_cnt_q);
      if (end_reason == DROP_FULL) full_cnt_q <= sat_inc(full_cnt_q);
      if (end_reason == DROP_NONE) frm_cnt_q <= sat_inc(frm_cnt_q);
    end
  end

  assign Drop_error_count = err_cnt_q;
  assign Drop_len_count   = lenc_cnt_q;
  assign Drop_full_count  = full_cnt_q;
  assign Frame_count      = frm_cnt_q;
`endif

endmodule

// File: tb/tb_gmii_width_buffer.sv
// Directed bench for gmii_width_buffer (4-byte words, 16-word RAM,
// 64-byte max frame): packing, drops, back-pressure and reset.
module tb_gmii_width_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   mode = 1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   bubbles = 0;
  int   hold_err = 0;

  always #5 clk = ~clk;

  gmii_width_buffer_if #(
    .OUTPUT_BYTES  (4),
    .MAX_FRAME_LEN (64)
  ) bus ();

`ifdef GMII_WIDTH_BUFFER_STATS_EN
  logic [15:0] s_err, s_len, s_full, s_frm;
`endif

  gmii_width_buffer #(
    .OUTPUT_BYTES  (4),
    .DATA_DEPTH    (16),
    .FRAME_DEPTH   (8),
    .MAX_FRAME_LEN (64)
  ) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
`ifdef GMII_WIDTH_BUFFER_STATS_EN
    ,
    .Drop_error_count (s_err),
    .Drop_len_count   (s_len),
    .Drop_full_count  (s_full),
    .Frame_count      (s_frm)
`endif
  );

  typedef struct {
    logic [31:0] data;
    int          bytes;
    bit          last;
    int          len;
  } beat_t;

  beat_t rx[$];

  // sink ready: 0 = stall, 1 = always, 2 = random
  initial begin
    bus.Output_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.Output_ready = (mode == 1) ||
        (mode == 2 && $urandom_range(0, 9) < 6);
    end
  end

  bit          in_frm = 0;
  bit          stall = 0;
  logic [31:0] p_data;
  int          p_bytes;
  bit          p_last;

  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      in_frm = 0;
      stall  = 0;
    end else begin
      if (stall && (!bus.Output_valid ||
          bus.Output_data !== p_data ||
          int'(bus.Output_bytes) != p_bytes ||
          bus.Output_last != p_last))
        hold_err++;
      if (in_frm && !bus.Output_valid) bubbles++;
      stall   = bus.Output_valid && !bus.Output_ready;
      p_data  = bus.Output_data;
      p_bytes = int'(bus.Output_bytes);
      p_last  = bus.Output_last;
      if (bus.Output_valid && bus.Output_ready) begin
        b.data  = bus.Output_data;
        b.bytes = int'(bus.Output_bytes);
        b.last  = bus.Output_last;
        b.len   = int'(bus.Output_length);
        rx.push_back(b);
        in_frm = !bus.Output_last;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int len, input int err_at,
                      input int seed, input int gap);
    for (int i = 0; i < len; i++) begin
      bus.Input_valid = 1'b1;
      bus.Input_data  = 8'(seed + i);
      bus.Input_error = (i == err_at);
      tick(1);
    end
    bus.Input_valid = 1'b0;
    bus.Input_error = 1'b0;
    tick(gap);
  endtask

  task automatic check_frame(input string tag, input int len,
                             input int seed);
    int          nb;
    int          err;
    beat_t       b;
    logic [31:0] w;
    nb  = (len + 3) / 4;
    err = 0;
    if (rx.size() < nb) begin
      chk({tag, "_beats"}, rx.size(), nb);
      rx.delete();
      return;
    end
    for (int k = 0; k < nb; k++) begin
      b = rx.pop_front();
      w = '0;
      for (int l = 0; l < 4; l++)
        if (k * 4 + l < len) w[l*8 +: 8] = 8'(seed + k * 4 + l);
      if (b.data !== w) err++;
      if (b.bytes != ((k == nb - 1) ? ((len - 1) % 4) + 1 : 4)) err++;
      if (b.last != (k == nb - 1)) err++;
      if (b.len != len) err++;
    end
    chk(tag, err, 0);
  endtask

  int lens[6] = '{5, 24, 1, 13, 8, 22};

  initial begin
    bus.Input_valid = 1'b0;
    bus.Input_error = 1'b0;
    bus.Input_data  = 8'h00;
    tick(3);
    chk("rst_valid", bus.Output_valid, 0);
    chk("rst_acc", bus.Input_accepted, 0);
    chk("rst_len", bus.Output_length, 0);
    chk("rst_data", bus.Output_data, 0);
    chk("rst_bytes", bus.Output_bytes, 0);
    chk("rst_last", bus.Output_last, 0);
    rst_n = 1'b1;
    tick(2);

    // 10-byte frame: 4,4,2 bytes
    send(10, -1, 0, 0);
    chk("acc_early", bus.Input_accepted, 0);
    tick(1);
    chk("acc_10", bus.Input_accepted, 1);
    tick(20);
    chk("fA_nbeats", rx.size(), 3);
    if (rx.size() == 3) begin
      chk("fA_b0", rx[0].bytes, 4);
      chk("fA_b1", rx[1].bytes, 4);
      chk("fA_b2", rx[2].bytes, 2);
      chk("fA_d2", rx[2].data, 32'h0000_0908);
      chk("fA_last", rx[2].last, 1);
      chk("fA_len", rx[0].len, 10);
    end
    check_frame("fA", 10, 0);

    // 1-byte frame, then errored 7-byte frame
    send(1, -1, 8'h55, 1);
    chk("acc_1", bus.Input_accepted, 1);
    send(7, 5, 8'hA0, 1);
    chk("acc_err", bus.Input_accepted, 0);
    tick(20);
    check_frame("f1b", 1, 8'h55);
    chk("err_not_out", rx.size(), 0);

    // oversize then max-size
    send(65, -1, 8'h10, 1);
    chk("acc_65", bus.Input_accepted, 0);
    send(64, -1, 8'h80, 1);
    chk("acc_64", bus.Input_accepted, 1);
    tick(40);
    chk("beats64", rx.size(), 16);
    check_frame("f64", 64, 8'h80);

    // data RAM fills with the sink stalled
    mode = 0;
    tick(1);
    for (int f = 0; f < 5; f++) begin
      send(16, -1, 8'h20 + f * 16, 1);
      chk($sformatf("acc_full%0d", f), bus.Input_accepted, f < 4);
    end
    chk("stall_valid", bus.Output_valid, 1);
    chk("stall_data", bus.Output_data, 32'h2322_2120);
    chk("stall_len", bus.Output_length, 16);
    mode = 1;
    tick(100);
    for (int f = 0; f < 4; f++)
      check_frame($sformatf("ffull%0d", f), 16, 8'h20 + f * 16);
    chk("full_left", rx.size(), 0);

    // random back-pressure
    mode = 2;
    for (int f = 0; f < 6; f++) begin
      send(lens[f], -1, f * 8'h11 + 3, 40);
      chk($sformatf("acc_rnd%0d", f), bus.Input_accepted, 1);
    end
    mode = 1;
    tick(100);
    for (int f = 0; f < 6; f++)
      check_frame($sformatf("frnd%0d", f), lens[f], f * 8'h11 + 3);
    chk("rnd_left", rx.size(), 0);

    // reset mid-output and mid-input
    mode = 0;
    tick(1);
    send(16, -1, 8'h40, 1);
    chk("acc_pre_rst", bus.Input_accepted, 1);
    tick(5);
    chk("pre_rst_valid", bus.Output_valid, 1);
    for (int i = 0; i < 3; i++) begin
      bus.Input_valid = 1'b1;
      bus.Input_data  = 8'(8'hE0 + i);
      tick(1);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.Output_valid, 0);
    chk("mid_rst_acc", bus.Input_accepted, 0);
    chk("mid_rst_data", bus.Output_data, 0);
    chk("mid_rst_len", bus.Output_length, 0);
    chk("mid_rst_last", bus.Output_last, 0);
    bus.Input_valid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    mode  = 1;
    tick(2);
    send(6, -1, 8'h60, 1);
    chk("acc_post_rst", bus.Input_accepted, 1);
    tick(30);
    check_frame("fpost", 6, 8'h60);
    chk("post_left", rx.size(), 0);

    chk("bubbles", bubbles, 0);
    chk("hold", hold_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
